regfile_mp: RTL and testbench

Parametrised multi-port integer register file, the successor to the fixed 32x32 core register file. It provides NUM_RD combinational read ports, a core writeback port (A), and a coprocessor/accelerator write port (B). It adds optional write-to-read bypass, write collision detection, and a sequenced clear engine. It sits in the ID stage, fed by MEM/WB writeback and the accelerator result path.

---
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_RD combinational reads, core (A) and accelerator (B) write
// ports with optional same-cycle bypass, collision/drop pulses and a sequenced clear engine.
module regfile_mp #(
   parameter int XLEN    = 32,
   parameter int DEPTH   = 32,
   parameter int NUM_RD  = 2,
   parameter int BYPASS  = 1,
   parameter int SP_IDX  = 2,
   parameter int SP_INIT = 1020,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   Rst,
   input  logic [NUM_RD*AW-1:0]   rd_addr,
   output logic [NUM_RD*XLEN-1:0] rd_data,
   input  logic                   wa_en,
   input  logic [AW-1:0]          wa_addr,
   input  logic [XLEN-1:0]        wa_data,
   input  logic                   hold,
   input  logic                   wb_en,
   input  logic [AW-1:0]          wb_addr,
   input  logic [XLEN-1:0]        wb_data,
   input  logic                   clr_req,
   output logic                   busy,
   output logic                   collision,
   output logic                   drop
);

   localparam logic [XLEN-1:0] SP_VAL = XLEN'(SP_INIT);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t          state;
   logic [AW-1:0]   idx;
   logic [XLEN-1:0] regs [DEPTH];

   logic req_a, req_b, we_a, we_b;

   // Index 0 is never a write target, so requests to it are neither effective nor dropped.
   assign req_a = wa_en & ~hold & (wa_addr != '0);
   assign req_b = wb_en & (wb_addr != '0);
   assign we_a  = req_a & ~busy;
   assign we_b  = req_b & ~busy;

   always_ff @(posedge clk) begin
      if (Rst) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= (i == SP_IDX) ? SP_VAL : '0;
         state     <= IDLE;
         idx       <= '0;
         busy      <= 1'b0;
         collision <= 1'b0;
         drop      <= 1'b0;
      end else begin
         collision <= we_a & we_b & (wa_addr == wb_addr);
         drop      <= busy & (req_a | req_b);
         if (we_a) regs[wa_addr] <= wa_data;
         // Later assignment wins, so B takes precedence on a shared index.
         if (we_b) regs[wb_addr] <= wb_data;
         case (state)
            IDLE: begin
               if (clr_req) begin
                  state <= CLEAR;
                  idx   <= AW'(1);
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               regs[idx] <= (idx == AW'(SP_IDX)) ? SP_VAL : '0;
               if (idx == AW'(DEPTH - 1)) begin
                  state <= IDLE;
                  idx   <= '0;
                  busy  <= 1'b0;
               end else begin
                  idx <= idx + AW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      assign a = rd_addr[k*AW +: AW];
      always_comb begin
         d = regs[a];
         if (BYPASS != 0) begin
            if (we_b && (a == wb_addr))
               d = wb_data;
            else if (we_a && (a == wa_addr))
               d = wa_data;
         end
         if (a == '0) d = '0;
      end
      assign rd_data[k*XLEN +: XLEN] = d;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypassing and non-bypassing instances share stimulus; directed table,
// clear / reset-mid-clear sequences and random traffic against a behavioural model.
module tb_regfile_mp;
   localparam int XLEN = 32, DEPTH = 32, NUM_RD = 2, AW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst, wa_en, hold, wb_en, clr_req;
   logic [AW-1:0]          wa_addr, wb_addr;
   logic [XLEN-1:0]        wa_data, wb_data;
   logic [NUM_RD*AW-1:0]   rd_addr;
   logic [NUM_RD*XLEN-1:0] rd_b, rd_n;
   logic                   busy_b, busy_n, col_b, col_n, drop_b, drop_n;

   regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .BYPASS(1), .SP_IDX(2), .SP_INIT(1020)) u_byp (
      .clk(clk), .Rst(rst), .rd_addr(rd_addr), .rd_data(rd_b),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data), .hold(hold),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .clr_req(clr_req), .busy(busy_b), .collision(col_b), .drop(drop_b));

   regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .BYPASS(0), .SP_IDX(2), .SP_INIT(1020)) u_nob (
      .clk(clk), .Rst(rst), .rd_addr(rd_addr), .rd_data(rd_n),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data), .hold(hold),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .clr_req(clr_req), .busy(busy_n), .collision(col_n), .drop(drop_n));

   int n_vec = 0;
   int n_bad = 0;

   // Behavioural model: storage array plus count of clear cycles still to run.
   logic [XLEN-1:0] m_mem [DEPTH];
   int              m_left;
   bit              m_col, m_drop;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void model_clock();
      bit ra, rb, ea, eb;
      int ci;
      if (rst) begin
         foreach (m_mem[i]) m_mem[i] = '0;
         m_mem[2] = 32'd1020;
         m_left = 0;
         m_col  = 0;
         m_drop = 0;
         return;
      end
      ra = wa_en && !hold && (wa_addr != 0);
      rb = wb_en && (wb_addr != 0);
      ea = ra && (m_left == 0);
      eb = rb && (m_left == 0);
      m_col  = ea && eb && (wa_addr == wb_addr);
      m_drop = (m_left > 0) && (ra || rb);
      if (ea) m_mem[wa_addr] = wa_data;
      if (eb) m_mem[wb_addr] = wb_data;
      if (m_left > 0) begin
         ci = DEPTH - m_left;
         m_mem[ci] = (ci == 2) ? 32'd1020 : 32'd0;
         m_left--;
      end else if (clr_req) begin
         m_left = DEPTH - 1;
      end
   endfunction

   function automatic logic [31:0] exp_rd(logic [AW-1:0] a, bit byp);
      if (a == 0) return 32'd0;
      if (byp && (m_left == 0)) begin
         if (wb_en && (wb_addr == a)) return wb_data;
         if (wa_en && !hold && (wa_addr == a)) return wa_data;
      end
      return m_mem[a];
   endfunction

   task automatic check_model();
      for (int k = 0; k < NUM_RD; k++) begin
         if (!rst) begin
            chk("rd_byp", rd_b[k*XLEN +: XLEN], exp_rd(rd_addr[k*AW +: AW], 1'b1));
            chk("rd_nob", rd_n[k*XLEN +: XLEN], exp_rd(rd_addr[k*AW +: AW], 1'b0));
         end
      end
      chk("busy_b", 32'(busy_b), 32'(m_left > 0));
      chk("busy_n", 32'(busy_n), 32'(m_left > 0));
      chk("coll_b", 32'(col_b), 32'(m_col));
      chk("coll_n", 32'(col_n), 32'(m_col));
      chk("drop_b", 32'(drop_b), 32'(m_drop));
      chk("drop_n", 32'(drop_n), 32'(m_drop));
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic step();
      #3;
      check_model();
      tick();
   endtask

   task automatic idle();
      rst = 0; wa_en = 0; hold = 0; wb_en = 0; clr_req = 0;
      wa_addr = '0; wb_addr = '0; wa_data = '0; wb_data = '0;
   endtask

   typedef struct {
      logic            rst, wa_en;
      logic [AW-1:0]   wa_addr;
      logic [XLEN-1:0] wa_data;
      logic            hold, wb_en;
      logic [AW-1:0]   wb_addr;
      logic [XLEN-1:0] wb_data;
      logic [AW-1:0]   rd0, rd1;
      logic [XLEN-1:0] eb0, eb1, en0, en1;
      logic            ecol;
   } vec_t;

   vec_t vt [$];

   function automatic vec_t mk(logic r, logic ae, logic [AW-1:0] aa, logic [XLEN-1:0] ad,
                               logic h, logic be, logic [AW-1:0] ba, logic [XLEN-1:0] bd,
                               logic [AW-1:0] r0, logic [AW-1:0] r1,
                               logic [XLEN-1:0] b0, logic [XLEN-1:0] b1,
                               logic [XLEN-1:0] n0, logic [XLEN-1:0] n1, logic c);
      vec_t v;
      v.rst = r; v.wa_en = ae; v.wa_addr = aa; v.wa_data = ad; v.hold = h;
      v.wb_en = be; v.wb_addr = ba; v.wb_data = bd; v.rd0 = r0; v.rd1 = r1;
      v.eb0 = b0; v.eb1 = b1; v.en0 = n0; v.en1 = n1; v.ecol = c;
      return v;
   endfunction

   int nb;

   initial begin
      idle();
      rd_addr = '0;
      foreach (m_mem[i]) m_mem[i] = '0;
      m_left = 0; m_col = 0; m_drop = 0;

      //          rst ae aa  ad            h  be ba  bd      r0 r1  eb0           eb1           en0           en1           col
      vt.push_back(mk(1, 0, 0, 0,            0, 0, 0,  0,      0, 0,  0,            0,            0,            0,            0));
      vt.push_back(mk(0, 0, 0, 0,            0, 0, 0,  0,      2, 5,  1020,         0,            1020,         0,            0));
      vt.push_back(mk(0, 1, 0, 32'hFFFF,     0, 0, 0,  0,      0, 2,  0,            1020,         0,            1020,         0));
      vt.push_back(mk(0, 0, 0, 0,            0, 0, 0,  0,      0, 7,  0,            0,            0,            0,            0));
      vt.push_back(mk(0, 1, 7, 32'hDEADBEEF, 0, 0, 0,  0,      7, 7,  32'hDEADBEEF, 32'hDEADBEEF, 0,            0,            0));
      vt.push_back(mk(0, 0, 0, 0,            0, 0, 0,  0,      7, 0,  32'hDEADBEEF, 0,            32'hDEADBEEF, 0,            0));
      vt.push_back(mk(0, 1, 9, 32'h11,       0, 1, 9,  32'h22, 9, 3,  32'h22,       0,            0,            0,            0));
      vt.push_back(mk(0, 0, 0, 0,            0, 0, 0,  0,      9, 10, 32'h22,       0,            32'h22,       0,            1));
      vt.push_back(mk(0, 1, 9, 32'h33,       0, 1, 10, 32'h44, 9, 10, 32'h33,       32'h44,       32'h22,       0,            0));
      vt.push_back(mk(0, 0, 0, 0,            0, 0, 0,  0,      9, 10, 32'h33,       32'h44,       32'h33,       32'h44,       0));
      vt.push_back(mk(0, 1, 3, 32'h55,       1, 1, 4,  32'h66, 3, 4,  0,            32'h66,       0,            0,            0));
      vt.push_back(mk(0, 0, 0, 0,            0, 0, 0,  0,      3, 4,  0,            32'h66,       0,            32'h66,       0));
      vt.push_back(mk(0, 1, 5, 32'h77,       1, 1, 5,  32'h88, 5, 5,  32'h88,       32'h88,       0,            0,            0));
      vt.push_back(mk(0, 0, 0, 0,            0, 0, 0,  0,      5, 9,  32'h88,       32'h33,       32'h88,       32'h33,       0));
      vt.push_back(mk(0, 1, 0, 32'h1,        0, 1, 0,  32'h2,  0, 0,  0,            0,            0,            0,            0));
      vt.push_back(mk(0, 0, 0, 0,            0, 0, 0,  0,      0, 5,  0,            32'h88,       0,            32'h88,       0));

      foreach (vt[i]) begin
         rst = vt[i].rst; wa_en = vt[i].wa_en; wa_addr = vt[i].wa_addr; wa_data = vt[i].wa_data;
         hold = vt[i].hold; wb_en = vt[i].wb_en; wb_addr = vt[i].wb_addr; wb_data = vt[i].wb_data;
         clr_req = 0;
         rd_addr = {vt[i].rd1, vt[i].rd0};
         #3;
         if (!vt[i].rst) begin
            chk("tbl_rd0_byp", rd_b[31:0],  vt[i].eb0);
            chk("tbl_rd1_byp", rd_b[63:32], vt[i].eb1);
            chk("tbl_rd0_nob", rd_n[31:0],  vt[i].en0);
            chk("tbl_rd1_nob", rd_n[63:32], vt[i].en1);
            chk("tbl_coll",    32'(col_b),  32'(vt[i].ecol));
            chk("tbl_busy",    32'(busy_b), 32'd0);
         end
         tick();
      end

      // Clear: preload everything, request clear, try a dropped B write during busy.
      idle();
      rd_addr = {5'd31, 5'd8};
      for (int i = 1; i < DEPTH; i += 2) begin
         wa_en = 1; wa_addr = AW'(i); wa_data = 32'hA5A5A5A5;
         wb_en = (i < DEPTH - 1); wb_addr = AW'(i + 1); wb_data = 32'hA5A5A5A5;
         step();
      end
      idle();
      clr_req = 1;
      step();
      clr_req = 0;
      nb = 0;
      for (int c = 0; c < 40; c++) begin
         wb_en = (c == 0); wb_addr = 5'd8; wb_data = 32'h1234;
         #3;
         check_model();
         if (c == 1) chk("drop_pulse", 32'(drop_b), 32'd1);
         if (c == 2) chk("drop_end", 32'(drop_b), 32'd0);
         if (busy_b) nb++;
         tick();
      end
      chk("busy_cycles", nb, 32'd31);
      idle();
      for (int i = 0; i < DEPTH; i += 2) begin
         rd_addr = {AW'(i + 1), AW'(i)};
         #3;
         chk("clr_val_lo", rd_b[31:0],  (i == 2) ? 32'd1020 : 32'd0);
         chk("clr_val_hi", rd_b[63:32], 32'd0);
         check_model();
         tick();
      end

      // Reset in the tenth cycle of a clear sequence.
      wa_en = 1; wa_addr = 5'd20; wa_data = 32'h5555;
      wb_en = 1; wb_addr = 5'd2;  wb_data = 32'h77;
      step();
      idle();
      clr_req = 1;
      step();
      clr_req = 0;
      for (int c = 1; c < 10; c++) step();
      rst = 1; clr_req = 1; wa_en = 1; wa_addr = 5'd20; wa_data = 32'h9999;
      #3;
      chk("busy_before_rst", 32'(busy_b), 32'd1);
      tick();
      idle();
      rd_addr = {5'd20, 5'd2};
      #3;
      chk("rst_busy", 32'(busy_b), 32'd0);
      chk("rst_sp", rd_b[31:0], 32'd1020);
      chk("rst_r20", rd_b[63:32], 32'd0);
      check_model();
      tick();
      clr_req = 1;
      step();
      clr_req = 0;
      #3;
      chk("clr_again", 32'(busy_b), 32'd1);
      check_model();
      tick();
      for (int c = 0; c < 35; c++) step();

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         rst     = ($urandom_range(0, 499) == 0);
         clr_req = ($urandom_range(0, 149) == 0);
         wa_en   = $urandom_range(0, 1) == 1;
         hold    = ($urandom_range(0, 3) == 0);
         wb_en   = $urandom_range(0, 1) == 1;
         wa_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         wb_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         wa_data = $urandom;
         wb_data = $urandom;
         rd_addr[0 +: AW]  = ($urandom_range(0, 1) == 1) ? wa_addr : AW'($urandom);
         rd_addr[AW +: AW] = ($urandom_range(0, 1) == 1) ? wb_addr : AW'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
